// File: rtl/chunked_adder.sv
`default_nettype none
// ============================================================================
// Module      : chunked_adder
// Description : Multi-cycle add/subtract unit processing CHUNK bits per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module chunked_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [IW-1:0]    idx_q, idx_d;

    logic [CHUNK:0]   w_chunk;
    logic [WIDTH-1:0] w_part_shift;

    // Operands shift right each cycle, so the active chunk is always the low one.
    assign w_chunk = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_q};

    generate
        if (NCH == 1) begin : g_single
            assign w_part_shift = w_chunk[CHUNK-1:0];
        end else begin : g_multi
            assign w_part_shift = {w_chunk[CHUNK-1:0], part_q[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        part_d  = part_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    part_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = w_chunk[CHUNK];
                part_d  = w_part_shift;
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    // Low chunk now holds the original MSBs of both operands.
                    state_d = ST_DONE;
                    sum_d   = w_part_shift;
                    cout_d  = w_chunk[CHUNK];
                    ovf_d   = (a_q[CHUNK-1] == b_q[CHUNK-1]) &&
                              (w_chunk[CHUNK-1] != a_q[CHUNK-1]);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_chunked_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_chunked_adder
// Description : Randomized self-checking bench for chunked_adder (32/8, 16/16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chunked_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, sub, cin;
    logic [31:0] a, b;
    logic        busy, done, cout, ovf;
    logic [31:0] sum;

    logic        s_start, s_sub, s_cin;
    logic [15:0] s_a, s_b;
    logic        s_busy, s_done, s_cout, s_ovf;
    logic [15:0] s_sum;

    chunked_adder #(.WIDTH(32), .CHUNK(8)) u_dut32 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    chunked_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(s_start), .sub(s_sub), .a(s_a), .b(s_b), .cin(s_cin),
        .busy(s_busy), .done(s_done), .sum(s_sum), .cout(s_cout), .ovf(s_ovf)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [33:0] last32 = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain arithmetic at width w.
    function automatic logic [33:0] model(input int w, input logic [31:0] ai, input logic [31:0] bi,
                                          input logic ci, input logic si);
        logic [32:0] mask, bp, full, s;
        logic        o;
        mask = (33'd1 << w) - 33'd1;
        bp   = si ? (~{1'b0, bi}) & mask : {1'b0, bi} & mask;
        full = {1'b0, ai} + bp + (si ? 33'd1 : {32'd0, ci});
        s    = full & mask;
        o    = (ai[w-1] == bp[w-1]) && (s[w-1] != ai[w-1]);
        return {o, full[w], s[31:0]};
    endfunction

    task automatic op32(input logic [31:0] ai, input logic [31:0] bi, input logic ci,
                        input logic si, input bit poke, input string tag);
        logic [33:0] exp;
        int cyc;
        exp = model(32, ai, bi, ci, si);
        @(negedge clk);
        a = ai; b = bi; cin = ci; sub = si; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " held"}, {ovf, cout, sum}, last32);
        cyc = 0;
        while (busy === 1'b1 && cyc < 64) begin
            cyc++;
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
            start = poke ? ((cyc == 1) ? 1'b1 : 1'($urandom)) : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, " busy_cycles"}, cyc, 4);
        check({tag, " done"}, done, 1'b1);
        check({tag, " result"}, {ovf, cout, sum}, exp);
        @(negedge clk);
        check({tag, " single_pulse"}, {busy, done}, 2'b00);
        check({tag, " idle_hold"}, {ovf, cout, sum}, exp);
        last32 = exp;
    endtask

    initial begin
        logic [33:0] exp16;
        logic [33:0] expq[$];
        int cyc, last_done, ndone, k;

        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        s_start = 1'b0; s_sub = 1'b0; s_cin = 1'b0; s_a = '0; s_b = '0;
        repeat (3) @(negedge clk);
        check("reset32", {busy, done, ovf, cout, sum}, '0);
        check("reset16", {s_busy, s_done, s_ovf, s_cout, s_sum}, '0);
        rst = 1'b0;

        op32(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, "add_wrap");
        op32(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, "add_ovf");
        op32(32'h00000010, 32'h00000020, 1'b1, 1'b0, 1'b0, "add_cin");
        op32(32'h00000005, 32'h00000007, 1'b0, 1'b1, 1'b0, "sub_borrow");
        op32(32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b0, "sub_ovf");
        op32(32'h12345678, 32'h0F0F0F0F, 1'b1, 1'b0, 1'b1, "restart_ignored");

        // Abort in the second RUN cycle.
        @(negedge clk);
        a = 32'hDEADBEEF; b = 32'h11111111; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outputs", {busy, done, ovf, cout, sum}, '0);
        for (int i = 0; i < 6; i++) begin
            check("abort_no_done", done, 1'b0);
            @(negedge clk);
        end
        last32 = '0;
        op32(32'hCAFEF00D, 32'h01010101, 1'b1, 1'b0, 1'b0, "after_abort");

        for (int i = 0; i < 30; i++) begin
            logic [31:0] ra;
            ra = $urandom;
            if (i % 5 == 0) ra = 32'hFFFFFFFF;
            op32(ra, $urandom, 1'($urandom), 1'($urandom), (i % 4 == 0), $sformatf("rnd%0d", i));
        end

        // Single-chunk instance: latency of one RUN cycle.
        exp16 = model(16, 32'h0000FFFF, 32'h0000FFFF, 1'b1, 1'b0);
        @(negedge clk);
        s_a = 16'hFFFF; s_b = 16'hFFFF; s_cin = 1'b1; s_sub = 1'b0; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        cyc = 0;
        while (s_busy === 1'b1 && cyc < 16) begin
            cyc++;
            @(negedge clk);
        end
        check("w16 busy_cycles", cyc, 1);
        check("w16 done", s_done, 1'b1);
        check("w16 result", {s_ovf, s_cout, 16'h0000, s_sum}, exp16);
        check("w16 expected", {s_cout, s_sum}, 17'h1FFFF);
        @(negedge clk);
        check("w16 single_pulse", s_done, 1'b0);

        // Back-to-back starts issued while done is high.
        @(negedge clk);
        s_a = 16'($urandom); s_b = 16'($urandom); s_cin = 1'($urandom); s_sub = 1'($urandom);
        s_start = 1'b1;
        expq.push_back(model(16, {16'h0, s_a}, {16'h0, s_b}, s_cin, s_sub));
        k = 1; cyc = 0; ndone = 0; last_done = 0;
        while (ndone < 6 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (s_done === 1'b1) begin
                if (ndone > 0) check("b2b gap", cyc - last_done, 2);
                check($sformatf("b2b result%0d", ndone), {s_ovf, s_cout, 16'h0000, s_sum},
                      expq.pop_front());
                last_done = cyc;
                ndone++;
                if (k < 6) begin
                    s_a = 16'($urandom); s_b = 16'($urandom);
                    s_cin = 1'($urandom); s_sub = 1'($urandom);
                    expq.push_back(model(16, {16'h0, s_a}, {16'h0, s_b}, s_cin, s_sub));
                    k++;
                end else begin
                    s_start = 1'b0;
                end
            end
        end
        s_start = 1'b0;
        check("b2b count", ndone, 6);
        @(negedge clk);
        check("b2b end", {s_busy, s_done}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chunked_adder.md
CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning operand and result width in bits.
REQ-002 The module SHALL have parameter CHUNK, default 8, meaning bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, and NCH = WIDTH/CHUNK.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock, rising edge active.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The module SHALL have port start, input, 1 bit: request to begin an operation.
REQ-006 The module SHALL have port sub, input, 1 bit: 0 selects add, 1 selects subtract.
REQ-007 The module SHALL have ports a and b, inputs, WIDTH bits each: operands.
REQ-008 The module SHALL have port cin, input, 1 bit: carry-in, used in add mode only.
REQ-009 The module SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-010 The module SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-011 The module SHALL have port sum, output, WIDTH bits: result.
REQ-012 The module SHALL have ports cout and ovf, outputs, 1 bit each: unsigned carry-out and signed overflow.

Function
REQ-013 The module SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 start sampled high in IDLE or DONE SHALL latch a, b^{WIDTH{sub}} and initial carry (sub ? 1 : cin), clear the chunk index, and enter RUN.
REQ-015 start SHALL be ignored in RUN, and operand changes during RUN SHALL NOT affect the result.
REQ-016 In RUN, each clock edge SHALL add chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) of the latched operands plus the running carry, store the CHUNK-bit partial result internally, propagate the carry, and increment k.
REQ-017 After the edge that processes chunk NCH-1, the FSM SHALL enter DONE and update sum, cout and ovf in the same edge.
REQ-018 busy SHALL be 1 exactly in RUN, which lasts NCH cycles; done SHALL be 1 exactly in DONE, which lasts one cycle.
REQ-019 If start is sampled at edge E0, done SHALL be high in the cycle following edge E_NCH. With CHUNK=WIDTH, latency SHALL be a single RUN cycle.
REQ-020 The result SHALL be {cout,sum} = a + b + cin for add and a + ~b + 1 for subtract; for subtract, cout=1 means no borrow.
REQ-021 ovf SHALL equal (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), where b' is the latched, possibly inverted, b.
REQ-022 sum, cout and ovf SHALL hold their last values through IDLE and the following RUN until the next DONE update.
REQ-023 If start is high in DONE, the next operation SHALL begin with no idle cycle (back-to-back).
REQ-024 Carry-out from the top chunk SHALL wrap: sum is modulo 2^WIDTH.

Reset
REQ-025 rst high at a clock edge SHALL force IDLE, busy=0, done=0, sum=0, cout=0 and ovf=0, and clear the internal operand, carry and index registers.
REQ-026 rst SHALL override start in the same cycle, and rst during RUN SHALL abort the operation with no done pulse.

Verification (WIDTH=32, CHUNK=8 unless stated)
REQ-027 The bench SHALL cover: add a=FFFFFFFF, b=00000001, cin=0 -> busy 4 cycles, then done, sum=00000000, cout=1, ovf=0.
REQ-028 The bench SHALL cover: add a=7FFFFFFF, b=00000001, cin=0 -> sum=80000000, cout=0, ovf=1; and a=00000010, b=00000020, cin=1 -> sum=00000031.
REQ-029 The bench SHALL cover: sub a=5, b=7 -> sum=FFFFFFFE, cout=0, ovf=0; and sub a=80000000, b=1 -> sum=7FFFFFFF, ovf=1, cout=1.
REQ-030 The bench SHALL cover: start re-asserted with new operands during RUN -> ignored, result of the first operation only, a single done pulse.
REQ-031 The bench SHALL cover: rst pulsed in the 2nd RUN cycle -> no done, all outputs 0 the next cycle, then a new start completes normally.
REQ-032 The bench SHALL cover: WIDTH=16, CHUNK=16, a=FFFF, b=FFFF, cin=1 -> 1 busy cycle, sum=FFFF, cout=1; and back-to-back starts at DONE -> consecutive done pulses NCH+1 cycles apart.
